// File: rtl/writeback_block.sv
// Writeback stage: W pipeline register, 15-entry register file with %rsp reset value,
// sticky halt on a faulting status and a retired-instruction counter.
module writeback_block (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        W_stall,
    input  logic        W_bubble,
    input  logic [2:0]  m_stat,
    input  logic [3:0]  M_Ins_Code,
    input  logic [63:0] M_Value_E,
    input  logic [63:0] m_Value_M,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    output logic [63:0] d_rvalA,
    output logic [63:0] d_rvalB,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_Ins_Code,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM,
    output logic        halted,
    output logic [63:0] retired_count
);

    localparam logic [3:0]  REG_NONE  = 4'hF;
    localparam logic [2:0]  STAT_AOK  = 3'b000;
    localparam logic [3:0]  ICODE_NOP = 4'h1;
    localparam logic [63:0] RSP_INIT  = 64'd4000;

    logic [2:0]  w_stat_q,  w_stat_d;
    logic [3:0]  w_icode_q, w_icode_d;
    logic [63:0] w_vale_q,  w_vale_d;
    logic [63:0] w_valm_q,  w_valm_d;
    logic [3:0]  w_dste_q,  w_dste_d;
    logic [3:0]  w_dstm_q,  w_dstm_d;
    logic        w_valid_q, w_valid_d;
    logic        halted_q;
    logic [63:0] retired_q;
    logic [63:0] rf_q [15];

    logic retire;
    logic fault;

    // A stalled W holds its instruction, so it may only retire on the edge that releases it.
    assign retire = w_valid_q && (w_stat_q == STAT_AOK) && !halted_q && !W_stall;
    assign fault  = w_valid_q && (w_stat_q != STAT_AOK) && !halted_q;

    always_comb begin
        w_stat_d  = w_stat_q;
        w_icode_d = w_icode_q;
        w_vale_d  = w_vale_q;
        w_valm_d  = w_valm_q;
        w_dste_d  = w_dste_q;
        w_dstm_d  = w_dstm_q;
        w_valid_d = w_valid_q;
        if (!halted_q && !W_stall) begin
            if (W_bubble) begin
                w_stat_d  = STAT_AOK;
                w_icode_d = ICODE_NOP;
                w_dste_d  = REG_NONE;
                w_dstm_d  = REG_NONE;
                w_valid_d = 1'b0;
            end else begin
                w_stat_d  = m_stat;
                w_icode_d = M_Ins_Code;
                w_vale_d  = M_Value_E;
                w_valm_d  = m_Value_M;
                w_dste_d  = M_dstE;
                w_dstm_d  = M_dstM;
                w_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_stat_q  <= STAT_AOK;
            w_icode_q <= ICODE_NOP;
            w_vale_q  <= 64'd0;
            w_valm_q  <= 64'd0;
            w_dste_q  <= REG_NONE;
            w_dstm_q  <= REG_NONE;
            w_valid_q <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= 64'd0;
        end else begin
            w_stat_q  <= w_stat_d;
            w_icode_q <= w_icode_d;
            w_vale_q  <= w_vale_d;
            w_valm_q  <= w_valm_d;
            w_dste_q  <= w_dste_d;
            w_dstm_q  <= w_dstm_d;
            w_valid_q <= w_valid_d;
            if (fault) begin
                halted_q <= 1'b1;
            end
            if (retire) begin
                retired_q <= retired_q + 64'd1;
            end
        end
    end

    // valM is written second so it wins when both destinations name the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                rf_q[i] <= (i == 4) ? RSP_INIT : 64'd0;
            end
        end else if (retire) begin
            if (w_dste_q != REG_NONE) begin
                rf_q[w_dste_q] <= w_vale_q;
            end
            if (w_dstm_q != REG_NONE) begin
                rf_q[w_dstm_q] <= w_valm_q;
            end
        end
    end

    assign d_rvalA = (d_srcA == REG_NONE) ? 64'd0 : rf_q[d_srcA];
    assign d_rvalB = (d_srcB == REG_NONE) ? 64'd0 : rf_q[d_srcB];

    assign W_stat        = w_stat_q;
    assign W_Ins_Code    = w_icode_q;
    assign W_valE        = w_vale_q;
    assign W_valM        = w_valm_q;
    assign W_dstE        = w_dste_q;
    assign W_dstM        = w_dstm_q;
    assign halted        = halted_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_writeback_block.sv
// Bench for writeback_block: retire-ordered scoreboard of expected register writes
// plus directed checks for reset, stall, halt and reset-abort behaviour.
module tb_writeback_block;

    logic        clk;
    logic        rst_n;
    logic        W_stall;
    logic        W_bubble;
    logic [2:0]  m_stat;
    logic [3:0]  M_Ins_Code;
    logic [63:0] M_Value_E;
    logic [63:0] m_Value_M;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [63:0] d_rvalA;
    logic [63:0] d_rvalB;
    logic [2:0]  W_stat;
    logic [3:0]  W_Ins_Code;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic        halted;
    logic [63:0] retired_count;

    writeback_block dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .W_stall       (W_stall),
        .W_bubble      (W_bubble),
        .m_stat        (m_stat),
        .M_Ins_Code    (M_Ins_Code),
        .M_Value_E     (M_Value_E),
        .m_Value_M     (m_Value_M),
        .M_dstE        (M_dstE),
        .M_dstM        (M_dstM),
        .d_srcA        (d_srcA),
        .d_srcB        (d_srcB),
        .d_rvalA       (d_rvalA),
        .d_rvalB       (d_rvalB),
        .W_stat        (W_stat),
        .W_Ins_Code    (W_Ins_Code),
        .W_valE        (W_valE),
        .W_valM        (W_valM),
        .W_dstE        (W_dstE),
        .W_dstM        (W_dstM),
        .halted        (halted),
        .retired_count (retired_count)
    );

    // Scoreboard entry: {dstE, valE, dstM, valM}
    localparam int EW = 4 + 64 + 4 + 64;
    logic [EW-1:0] exp_q[$];

    int          checks   = 0;
    int          failures = 0;
    int          n_exp    = 0;
    logic [63:0] last_cnt = 64'd0;
    logic [63:0] cnt_ref;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        exp_q.delete();
        n_exp = 0;
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    // Holds W for n_stall edges (with random bubble, which stall must override),
    // then latches the instruction on one unstalled edge.
    task automatic send(input logic [2:0] st, input logic [3:0] ic,
                        input logic [63:0] ve, input logic [63:0] vm,
                        input logic [3:0] de, input logic [3:0] dm,
                        input int n_stall, input bit expect_retire);
        m_stat     = st;
        M_Ins_Code = ic;
        M_Value_E  = ve;
        m_Value_M  = vm;
        M_dstE     = de;
        M_dstM     = dm;
        for (int i = 0; i < n_stall; i++) begin
            W_stall  = 1'b1;
            W_bubble = 1'($urandom_range(0, 1));
            step();
        end
        W_stall  = 1'b0;
        W_bubble = 1'b0;
        step();
        if (expect_retire) begin
            exp_q.push_back({de, ve, dm, vm});
            n_exp++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            W_stall  = 1'b0;
            W_bubble = 1'b1;
            m_stat   = 3'($urandom_range(0, 7));
            M_dstE   = 4'($urandom_range(0, 15));
            M_dstM   = 4'($urandom_range(0, 15));
            step();
        end
    endtask

    task automatic read_a(input logic [3:0] r, input string tag, input logic [63:0] exp);
        d_srcA = r;
        #1;
        check_eq(tag, d_rvalA, exp);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            last_cnt = 64'd0;
        end else if (retired_count != last_cnt) begin
            logic [EW-1:0] e;
            logic [3:0]    de, dm;
            logic [63:0]   ve, vm;
            check_eq("retire_step", retired_count, last_cnt + 64'd1);
            last_cnt = retired_count;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_retire", retired_count, 64'd0);
            end else begin
                e = exp_q.pop_front();
                {de, ve, dm, vm} = e;
                if (dm != 4'hF) begin
                    d_srcB = dm;
                    #1;
                    check_eq("sb_valM", d_rvalB, vm);
                end
                if (de != 4'hF && de != dm) begin
                    d_srcB = de;
                    #1;
                    check_eq("sb_valE", d_rvalB, ve);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b1;
        W_stall = 1'b0; W_bubble = 1'b1;
        m_stat = 3'd0; M_Ins_Code = 4'd1; M_Value_E = '0; m_Value_M = '0;
        M_dstE = 4'hF; M_dstM = 4'hF;
        d_srcA = 4'hF; d_srcB = 4'hF;
        #1;
        do_reset();

        check_eq("rst_W_stat", 64'(W_stat), 64'd0);
        check_eq("rst_W_icode", 64'(W_Ins_Code), 64'd1);
        check_eq("rst_W_valE", W_valE, 64'd0);
        check_eq("rst_W_valM", W_valM, 64'd0);
        check_eq("rst_W_dstE", 64'(W_dstE), 64'hF);
        check_eq("rst_W_dstM", 64'(W_dstM), 64'hF);
        check_eq("rst_halted", 64'(halted), 64'd0);
        check_eq("rst_count", retired_count, 64'd0);
        read_a(4'd4, "rst_rsp", 64'd4000);
        read_a(4'd2, "rst_r2", 64'd0);
        read_a(4'hF, "read_none", 64'd0);

        // irmovq then bubble
        send(3'b000, 4'h3, 64'h55, 64'h0, 4'd2, 4'hF, 0, 1'b1);
        read_a(4'd2, "irmov_not_yet", 64'd0);
        idle(1);
        read_a(4'd2, "irmov_r2", 64'h55);
        check_eq("irmov_count", retired_count, 64'd1);
        read_a(4'd4, "irmov_rsp", 64'd4000);

        // mrmovq
        send(3'b000, 4'h5, 64'h0, 64'h1234, 4'hF, 4'd3, 0, 1'b1);
        idle(1);
        read_a(4'd3, "mrmov_r3", 64'h1234);

        // popq %rsp: valM wins
        send(3'b000, 4'hB, 64'd4008, 64'h77, 4'd4, 4'd4, 0, 1'b1);
        idle(1);
        read_a(4'd4, "popq_rsp", 64'h77);

        // no destinations still retires
        cnt_ref = retired_count;
        send(3'b000, 4'h1, 64'h9, 64'h9, 4'hF, 4'hF, 0, 1'b1);
        idle(1);
        check_eq("nodst_count", retired_count, cnt_ref + 64'd1);

        // stall held three cycles on a valid instruction
        send(3'b000, 4'h6, 64'hA7, 64'h0, 4'd7, 4'hF, 0, 1'b1);
        cnt_ref = retired_count;
        for (int i = 0; i < 3; i++) begin
            W_stall  = 1'b1;
            W_bubble = 1'b1;
            M_Value_E = 64'($urandom);
            M_dstE    = 4'd8;
            step();
            check_eq("stall_W_valE", W_valE, 64'hA7);
            check_eq("stall_W_dstE", 64'(W_dstE), 64'd7);
            check_eq("stall_count", retired_count, cnt_ref);
        end
        idle(1);
        check_eq("stall_release_count", retired_count, cnt_ref + 64'd1);
        read_a(4'd7, "stall_r7", 64'hA7);

        // random traffic with random stalls
        for (int k = 0; k < 40; k++) begin
            send(3'b000, 4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 2), 1'b1);
        end
        idle(2);
        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
        check_eq("total_count", retired_count, 64'(n_exp));

        // reset mid-operation aborts the pending write
        send(3'b000, 4'h3, 64'hAB, 64'h0, 4'd6, 4'hF, 0, 1'b1);
        do_reset();
        read_a(4'd6, "abort_r6", 64'd0);
        check_eq("abort_count", retired_count, 64'd0);
        read_a(4'd4, "abort_rsp", 64'd4000);

        // HLT: halts, later write ignored, W frozen
        send(3'b000, 4'h3, 64'h22, 64'h0, 4'd2, 4'hF, 0, 1'b1);
        send(3'b100, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 0, 1'b0);
        check_eq("hlt_not_yet", 64'(halted), 64'd0);
        send(3'b000, 4'h3, 64'h99, 64'h0, 4'd1, 4'hF, 0, 1'b0);
        check_eq("hlt_halted", 64'(halted), 64'd1);
        for (int i = 0; i < 4; i++) begin
            W_stall  = 1'(i % 2);
            W_bubble = 1'(i / 2);
            M_Value_E = 64'h1111;
            step();
        end
        read_a(4'd1, "hlt_r1", 64'd0);
        read_a(4'd2, "hlt_r2", 64'h22);
        check_eq("hlt_count", retired_count, 64'd1);
        check_eq("hlt_W_valE", W_valE, 64'h99);
        check_eq("hlt_sticky", 64'(halted), 64'd1);

        // ADR fault then reset pulse
        do_reset();
        send(3'b010, 4'h3, 64'h5555, 64'h0, 4'd5, 4'hF, 0, 1'b0);
        idle(1);
        check_eq("adr_halted", 64'(halted), 64'd1);
        idle(2);
        read_a(4'd5, "adr_r5", 64'd0);
        check_eq("adr_count", retired_count, 64'd0);
        do_reset();
        check_eq("adr_rst_halted", 64'(halted), 64'd0);
        check_eq("adr_rst_count", retired_count, 64'd0);
        read_a(4'd4, "adr_rst_rsp", 64'd4000);

        // first edge after release obeys normal priority
        send(3'b000, 4'h3, 64'hC3, 64'h0, 4'd9, 4'hF, 0, 1'b1);
        check_eq("post_rst_W_valE", W_valE, 64'hC3);
        idle(2);
        read_a(4'd9, "post_rst_r9", 64'hC3);
        check_eq("post_rst_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_block.md
WRITEBACK_BLOCK -- requirements
Module: writeback_block

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: clock, rising-edge active.
REQ-003 Port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-004 Port W_stall, input, 1 bit: hold the W pipeline register.
REQ-005 Port W_bubble, input, 1 bit: load a bubble into the W register.
REQ-006 Port m_stat, input, 3 bits: memory-stage status. Encoding: 000 AOK, 001 INS, 010 ADR, 100 HLT.
REQ-007 Port M_Ins_Code, input, 4 bits: memory-stage icode.
REQ-008 Port M_Value_E, input, 64 bits signed: memory-stage valE.
REQ-009 Port m_Value_M, input, 64 bits signed: memory-stage valM.
REQ-010 Port M_dstE, input, 4 bits: destination for valE; 4'hF means none.
REQ-011 Port M_dstM, input, 4 bits: destination for valM; 4'hF means none.
REQ-012 Ports d_srcA and d_srcB, input, 4 bits each: register-file read addresses.
REQ-013 Ports d_rvalA and d_rvalB, output, 64 bits each: combinational read data; return 0 when the address is 4'hF.
REQ-014 Ports W_stat (3 bits), W_Ins_Code (4 bits), W_valE (64 bits), W_valM (64 bits), W_dstE (4 bits) and W_dstM (4 bits), outputs: W register contents, used for forwarding.
REQ-015 Port halted, output, 1 bit: sticky flag, processor stopped.
REQ-016 Port retired_count, output, 64 bits: number of retired instructions.

Function
REQ-017 The block SHALL hold a W register and a 15 x 64-bit register file (indices 0-14), plus a W_valid bit.
REQ-018 At each rising edge with halted=0, the W register SHALL update with this priority:
  - W_stall=1: hold all W state.
  - W_bubble=1: W_stat=000, W_Ins_Code=1, W_dstE=W_dstM=F, W_valid=0.
  - Otherwise: latch the M-stage inputs and set W_valid=1.
REQ-019 A retire event SHALL occur at a rising edge when W_valid=1, W_stat=000, halted=0 and W_stall=0.
REQ-020 On a retire event, if W_dstE!=F, the block SHALL write rf[W_dstE]=W_valE.
REQ-021 On a retire event, if W_dstM!=F, the block SHALL write rf[W_dstM]=W_valM.
REQ-022 When W_dstE equals W_dstM (and is not F), valM SHALL win.
REQ-023 On a retire event, retired_count SHALL increment by 1, wrapping modulo 2^64.
REQ-024 Register writes SHALL become visible on d_rvalA/d_rvalB the cycle after the edge; there is no internal bypass (forwarding is done upstream via the W_* outputs).
REQ-025 At a rising edge when W_valid=1 and W_stat!=000, the block SHALL:
  - set halted=1;
  - perform no register write;
  - not increment retired_count.
REQ-026 While halted=1, the block SHALL:
  - freeze the W register and ignore W_stall and W_bubble;
  - inhibit all register writes;
  - hold retired_count.
REQ-027 halted SHALL clear only on reset.
REQ-028 W_stall and W_bubble asserted together SHALL resolve as stall.
REQ-029 A bubble SHALL never write registers or change retired_count.
REQ-030 An M-stage input with m_stat=000 and both destinations F SHALL retire (count increments) with no register write.

Reset
REQ-031 While rst_n=0, asynchronously, the block SHALL set:
  - W_stat=000, W_Ins_Code=1, W_valE=0, W_valM=0, W_dstE=F, W_dstM=F, W_valid=0;
  - halted=0, retired_count=0;
  - rf[i]=0 for all i except rf[4] (%rsp)=64'd4000.
REQ-032 Reset asserted mid-operation SHALL abort any pending write.
REQ-033 The first active edge after reset release SHALL behave per REQ-018.

Verification
REQ-034 Reset, then irmovq (icode 3, valE=0x55, dstE=2, m_stat=000), then a bubble -> rf[2]=0x55 two edges later; retired_count=1; rf[4]=4000 throughout.
REQ-035 mrmovq with dstM=3, m_Value_M=0x1234, dstE=F -> rf[3]=0x1234; d_rvalA with d_srcA=3 reads 0x1234 on the next cycle.
REQ-036 popq to %rsp with dstE=4 (valE=4008) and dstM=4 (valM=0x77) -> rf[4]=0x77.
REQ-037 W_stall held 3 cycles on a valid AOK instruction -> W frozen; retired_count increments exactly once, after release.
REQ-038 m_stat=100 (HLT) enters W -> halted=1 at the next edge; a following AOK write to rf[1] is ignored; retired_count unchanged.
REQ-039 m_stat=010 (ADR) with dstE=5 -> no write to rf[5]; halted=1; rst_n pulse -> halted=0, retired_count=0, rf[4]=4000.
